mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control.sv | 195 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control unit with bounded memory waits.
// Outputs decode from the current state plus mem_ready/zero, and are forced low while reset_n is low.
module mips_mc_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl,
    output logic [1:0] pc_source,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       r_is_sw;
    logic       w_funct_ok;
    logic       w_op_ok;
    logic       w_wait_st;
    logic       w_timeout;
    logic [2:0] w_funct_ctl;

    always_comb begin
        w_funct_ctl = 3'b010;
        w_funct_ok  = 1'b1;
        case (funct)
            6'h20: w_funct_ctl = 3'b010;
            6'h22: w_funct_ctl = 3'b110;
            6'h24: w_funct_ctl = 3'b000;
            6'h25: w_funct_ctl = 3'b001;
            6'h2A: w_funct_ctl = 3'b111;
            default: w_funct_ok = 1'b0;
        endcase
    end

    assign w_op_ok = (op == OP_R) ? w_funct_ok
                   : (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A ready in the final allowed wait cycle still completes the access.
    assign w_timeout = w_wait_st && !mem_ready && (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = !w_op_ok ? S_FETCH
                                : (op == OP_LW || op == OP_SW) ? S_MEM_ADDR
                                : (op == OP_R) ? S_R_EXEC
                                : (op == OP_BEQ) ? S_BEQ
                                : (op == OP_J) ? S_JUMP
                                : S_ADDI_EXEC;
            S_MEM_ADDR:  w_next = r_is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    w_next = mem_ready ? S_MEM_WB : (w_timeout ? S_FETCH : S_MEM_RD);
            S_MEM_WR:    w_next = (mem_ready || w_timeout) ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_is_sw    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= (w_timeout || w_next != r_state) ? '0
                        : (w_wait_st && !mem_ready) ? r_wait_cnt + 8'd1 : r_wait_cnt;
            if (r_state == S_DECODE)
                r_is_sw <= (op == OP_SW);
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl    = 3'b000;
        pc_source  = 2'b00;
        state      = reset_n ? r_state : 4'd0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctl   = 3'b010;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    mem_err   = w_timeout;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    alu_ctl    = 3'b010;
                    illegal_op = !w_op_ok;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctl   = 3'b010;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    mem_err  = w_timeout;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    mem_err    = w_timeout;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = w_funct_ctl;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  = 1'b1;
                    alu_ctl    = 3'b110;
                    pc_source  = 2'b01;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: scoreboard bench for the multicycle control unit.
// Per-cycle expected output vectors are queued as stimulus is driven and compared on the falling edge.
module tb_mips_mc_control;
    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] RE = 4'd6, RW = 4'd7, BQ = 4'd8, JP = 4'd9, AE = 4'd10, AW = 4'd11;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, instr_done, illegal_op, mem_err;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_ctl;
    logic [3:0] state;
    logic [22:0] w_vec;
    logic [22:0] q[$];
    int n_chk = 0;
    int n_err = 0;

    mips_mc_control #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err), .alu_src_b(alu_src_b),
        .alu_ctl(alu_ctl), .pc_source(pc_source), .state(state)
    );

    always #5 clock = ~clock;

    assign w_vec = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                    alu_src_a, instr_done, illegal_op, mem_err, alu_src_b, alu_ctl, pc_source};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] ev(input logic [3:0] st, input logic rdy, input logic zr,
                                       input logic ill, input logic tmo, input logic [2:0] c);
        logic pe, iod, mr, mw, ir, m2r, rd, rw, a, dn, il, me;
        logic [1:0] b, ps;
        logic [2:0] ctl;
        {pe, iod, mr, mw, ir, m2r, rd, rw, a, dn, il, me} = '0;
        b = 2'b00; ps = 2'b00; ctl = 3'b000;
        case (st)
            F:      begin mr = 1; b = 2'b01; ctl = 3'b010; ir = rdy; pe = rdy; me = tmo; end
            D:      begin b = 2'b11; ctl = 3'b010; il = ill; end
            MA, AE: begin a = 1; b = 2'b10; ctl = 3'b010; end
            MR:     begin mr = 1; iod = 1; me = tmo; end
            MWB:    begin rw = 1; m2r = 1; dn = 1; end
            MW:     begin mw = 1; iod = 1; dn = rdy; me = tmo; end
            RE:     begin a = 1; ctl = c; end
            RW:     begin rw = 1; rd = 1; dn = 1; end
            BQ:     begin a = 1; ctl = 3'b110; ps = 2'b01; pe = zr; dn = 1; end
            JP:     begin ps = 2'b10; pe = 1; dn = 1; end
            AW:     begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {st, pe, iod, mr, mw, ir, m2r, rd, rw, a, dn, il, me, b, ctl, ps};
    endfunction

    always @(negedge clock)
        if (q.size() > 0)
            chk($sformatf("sb_st%0d", q[0][22:19]), w_vec, q.pop_front());

    task automatic cyc(input logic [3:0] st, input logic rdy, input logic tmo, input logic ill, input logic [2:0] c);
        mem_ready = rdy;
        q.push_back(ev(st, rdy, zero, ill, tmo, c));
        @(posedge clock);
        #1;
    endtask

    task automatic cyc_rst(input logic [3:0] st, input logic rdy, input logic [2:0] c);
        mem_ready = rdy;
        q.push_back(ev(st, rdy, zero, 1'b0, 1'b0, c));
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1 chk("rst_async", w_vec, 0);
        reset_n = 1'b1;
        #1 chk("rst_release", w_vec, ev(F, rdy, zero, 1'b0, 1'b0, 3'b0));
        @(posedge clock);
        #1;
    endtask

    logic [5:0] fn_tbl[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] ct_tbl[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
        #2 chk("reset_out", w_vec, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        op = 6'h23;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(MA, 1, 0, 0, 0); cyc(MR, 1, 0, 0, 0); cyc(MWB, 1, 0, 0, 0);
        op = 6'h2B;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0);
        op = 6'h23;
        cyc(MA, 1, 0, 0, 0);
        cyc(MW, 0, 0, 0, 0); cyc(MW, 0, 0, 0, 0); cyc(MW, 0, 0, 0, 0); cyc(MW, 1, 0, 0, 0);
        op = 6'h00;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tbl[i];
            cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(RE, 1, 0, 0, ct_tbl[i]); cyc(RW, 1, 0, 0, 0);
        end
        funct = 6'h27;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 1, 0);
        op = 6'h3F;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 1, 0);
        op = 6'h04; zero = 1'b1;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(BQ, 1, 0, 0, 0);
        zero = 1'b0;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(BQ, 1, 0, 0, 0);
        op = 6'h02;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(JP, 1, 0, 0, 0);
        op = 6'h08;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(AE, 1, 0, 0, 0); cyc(AW, 1, 0, 0, 0);
        op = 6'h23;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(MA, 1, 0, 0, 0);
        cyc(MR, 0, 0, 0, 0); cyc(MR, 0, 0, 0, 0); cyc(MR, 1, 0, 0, 0); cyc(MWB, 1, 0, 0, 0);
        cyc(F, 0, 0, 0, 0); cyc(F, 0, 0, 0, 0); cyc(F, 0, 0, 0, 0); cyc(F, 0, 1, 0, 0);
        op = 6'h02;
        cyc(F, 0, 0, 0, 0); cyc(F, 0, 0, 0, 0); cyc(F, 0, 0, 0, 0); cyc(F, 1, 0, 0, 0);
        cyc(D, 1, 0, 0, 0); cyc(JP, 1, 0, 0, 0);
        op = 6'h23;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(MA, 1, 0, 0, 0);
        cyc(MR, 0, 0, 0, 0); cyc(MR, 0, 0, 0, 0); cyc(MR, 0, 0, 0, 0); cyc(MR, 0, 1, 0, 0);
        op = 6'h2B;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(MA, 1, 0, 0, 0);
        cyc(MW, 0, 0, 0, 0); cyc(MW, 0, 0, 0, 0); cyc(MW, 0, 0, 0, 0); cyc(MW, 0, 1, 0, 0);
        op = 6'h00; funct = 6'h20;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc_rst(RE, 1, 3'b010);
        cyc(D, 1, 0, 0, 0); cyc(RE, 1, 0, 0, 3'b010); cyc(RW, 1, 0, 0, 0);
        op = 6'h2B;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(MA, 1, 0, 0, 0); cyc_rst(MW, 0, 3'b0);
        op = 6'h02;
        cyc(F, 1, 0, 0, 0); cyc(D, 1, 0, 0, 0); cyc(JP, 1, 0, 0, 0);
        @(negedge clock);
        #1 chk("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
